spi_loader: RTL and testbench

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/tiny_proc_pkg.sv | 24 ++
 rtl/sync_ff.sv | 26 ++
 rtl/spi_loader.sv | 195 +++++++++++++++++++
 tb/tb_spi_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_proc_pkg.sv
// Shared loader types and constants. Frame length follows LOADER_PARITY_EN
// (8 data bits, plus a trailing even-parity bit when the macro is defined).
package tiny_proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_I = 2'd1,
        ST_LOAD_D = 2'd2,
        ST_ERR    = 2'd3
    } loader_state_e;

`ifdef LOADER_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    localparam int DEF_IMEM_AW = 4;
    localparam int DEF_DMEM_AW = 4;
    localparam int BITCNT_W    = 4;
    // Bits held before the final sample; the last bit feeds wdata or the parity check directly.
    localparam int SREG_W      = FRAME_BITS - 1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff_q;
    logic [DEPTH-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= {DEPTH{RST_VAL}};
        else     ff_q <= ff_d;
    end

    assign q = ff_q[DEPTH-1];

endmodule

// File: rtl/spi_loader.sv
// Serial loader filling instruction/data memories and gating the processor.
// Define LOADER_PARITY_EN for 9-bit frames with even-parity checking.
import tiny_proc_pkg::*;

module spi_loader #(
    parameter int IMEM_AW     = DEF_IMEM_AW,
    parameter int DMEM_AW     = DEF_DMEM_AW,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               proc_en,
    input  logic               csi,
    input  logic               csd,
    input  logic               mosi,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [7:0]         wdata,
    output logic               proc_run,
    output logic               busy,
    output logic               err,
    output logic               ovf,
    output logic               perr
);

    localparam int NSYNC = 4;
    // Selects idle high, data and enable idle low: {proc_en, csi, csd, mosi}.
    localparam logic [NSYNC-1:0]    SYNC_RST = 4'b0110;
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_BITS - 1);

    logic [NSYNC-1:0] async_in;
    logic [NSYNC-1:0] sync_out;
    logic             proc_en_s, csi_s, csd_s, mosi_s;

    assign async_in = {proc_en, csi, csd, mosi};

    for (genvar i = 0; i < NSYNC; i++) begin : g_sync
        sync_ff #(
            .DEPTH   (SYNC_STAGES),
            .RST_VAL (SYNC_RST[i])
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_in[i]),
            .q   (sync_out[i])
        );
    end

    assign {proc_en_s, csi_s, csd_s, mosi_s} = sync_out;

    loader_state_e       state_q, state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [IMEM_AW-1:0]  iaddr_q, iaddr_d;
    logic [DMEM_AW-1:0]  daddr_q, daddr_d;
    logic                imem_we_q, imem_we_d;
    logic                dmem_we_q, dmem_we_d;
    logic                err_q, err_d;
    logic                ovf_q, ovf_d;
    logic                perr_q, perr_d;
    logic                proc_run_q, proc_run_d;
    logic                own_sel_n, oth_sel_n, frame_ok;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        sreg_d     = sreg_q;
        wdata_d    = wdata_q;
        iaddr_d    = iaddr_q;
        daddr_d    = daddr_q;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        err_d      = err_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        proc_run_d = proc_en_s && (state_q == ST_IDLE);
        own_sel_n  = 1'b1;
        oth_sel_n  = 1'b1;
        frame_ok   = 1'b0;

        // Address advances on the cycle the strobe is visible.
        if (imem_we_q) begin
            iaddr_d = iaddr_q + 1'b1;
            if (&iaddr_q) ovf_d = 1'b1;
        end
        if (dmem_we_q) begin
            daddr_d = daddr_q + 1'b1;
            if (&daddr_q) ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!csi_s && !csd_s) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (!csi_s) begin
                    state_d  = ST_LOAD_I;
                    bitcnt_d = '0;
                    iaddr_d  = '0;
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
                    perr_d   = 1'b0;
                end else if (!csd_s) begin
                    state_d  = ST_LOAD_D;
                    bitcnt_d = '0;
                    daddr_d  = '0;
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
                    perr_d   = 1'b0;
                end
            end
            ST_LOAD_I, ST_LOAD_D: begin
                own_sel_n = (state_q == ST_LOAD_I) ? csi_s : csd_s;
                oth_sel_n = (state_q == ST_LOAD_I) ? csd_s : csi_s;
                if (!oth_sel_n) begin
                    state_d  = ST_ERR;
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                end else if (own_sel_n) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                end else begin
                    sreg_d = {sreg_q[SREG_W-2:0], mosi_s};
                    if (bitcnt_q == LAST_BIT) begin
                        bitcnt_d = '0;
`ifdef LOADER_PARITY_EN
                        if (^{sreg_q, mosi_s}) begin
                            perr_d = 1'b1;
                        end else begin
                            wdata_d  = sreg_q;
                            frame_ok = 1'b1;
                        end
`else
                        wdata_d  = {sreg_q, mosi_s};
                        frame_ok = 1'b1;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                imem_we_d = frame_ok && (state_q == ST_LOAD_I);
                dmem_we_d = frame_ok && (state_q == ST_LOAD_D);
            end
            ST_ERR: begin
                if (csi_s && csd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            sreg_q     <= '0;
            wdata_q    <= '0;
            iaddr_q    <= '0;
            daddr_q    <= '0;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            proc_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sreg_q     <= sreg_d;
            wdata_q    <= wdata_d;
            iaddr_q    <= iaddr_d;
            daddr_q    <= daddr_d;
            imem_we_q  <= imem_we_d;
            dmem_we_q  <= dmem_we_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            proc_run_q <= proc_run_d;
        end
    end

    assign imem_we   = imem_we_q;
    assign imem_addr = iaddr_q;
    assign dmem_we   = dmem_we_q;
    assign dmem_addr = daddr_q;
    assign wdata     = wdata_q;
    assign proc_run  = proc_run_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign ovf       = ovf_q;
    assign perr      = perr_q;

endmodule

// File: tb/tb_spi_loader.sv
// Randomized bench for spi_loader: expected writes come from a transaction-level
// model (byte i of a load lands at address i mod 16); LOADER_PARITY_EN adds a parity case.
module tb_spi_loader;
    import tiny_proc_pkg::*;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst, proc_en, csi, csd, mosi;
    logic       imem_we, dmem_we, proc_run, busy, err, ovf, perr;
    logic [3:0] imem_addr, dmem_addr;
    logic [7:0] wdata;

    spi_loader #(
        .IMEM_AW     (4),
        .DMEM_AW     (4),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .proc_en   (proc_en),
        .csi       (csi),
        .csd       (csd),
        .mosi      (mosi),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .wdata     (wdata),
        .proc_run  (proc_run),
        .busy      (busy),
        .err       (err),
        .ovf       (ovf),
        .perr      (perr)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [12:0] act_q[$];   // {target, addr, data}, target 0 = imem
    logic [12:0] exp_q[$];
    logic [7:0]  bytes[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Write monitor: every strobe is logged for later comparison.
    always @(negedge clk) begin
        if (imem_we || dmem_we) chk("we_excl", 32'(imem_we & dmem_we), 0);
        if (imem_we) act_q.push_back({1'b0, imem_addr, wdata});
        if (dmem_we) act_q.push_back({1'b1, dmem_addr, wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit tgt);
        csi  = tgt;
        csd  = !tgt;
        mosi = 1'b0;
        tick();
    endtask

    task automatic send_bit(input bit b);
        mosi = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef LOADER_PARITY_EN
        send_bit(^b);
`endif
    endtask

    task automatic settle();
        csi  = 1'b1;
        csd  = 1'b1;
        mosi = 1'b0;
        repeat (SYNC + 5) tick();
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_n"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk(tag, 32'(act_q[i]), 32'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic load(input bit tgt);
        int n;
        n = bytes.size();
        start(tgt);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({tgt, 4'(i), bytes[i]});
            send_byte(bytes[i]);
            if (i == 0) chk("busy_ld", 32'(busy), 1);
        end
        settle();
        compare_writes("wr");
        chk("ovf",      32'(ovf),      32'(n >= 16));
        chk("err",      32'(err),      0);
        chk("busy",     32'(busy),     0);
        chk("perr",     32'(perr),     0);
        chk("proc_run", 32'(proc_run), 32'(proc_en));
    endtask

    initial begin
        rst = 1'b1; proc_en = 1'b1; csi = 1'b1; csd = 1'b1; mosi = 1'b0;
        repeat (3) tick();
        chk("rst_we",    32'({imem_we, dmem_we}), 0);
        chk("rst_addr",  32'({imem_addr, dmem_addr}), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_flags", 32'({proc_run, busy, err, ovf, perr}), 0);
        proc_en = 1'b0;
        rst     = 1'b0;
        repeat (SYNC + 3) tick();

        // Instruction load of two bytes.
        bytes.delete();
        bytes.push_back(8'hA5);
        bytes.push_back(8'h3C);
        load(1'b0);

        // Conflict: csd joins mid-frame of an instruction load.
        start(1'b0);
        repeat (4) send_bit(1'b1);
        csd = 1'b0;
        repeat (SYNC + 3) send_bit(1'b0);
        chk("cf_err",  32'(err),  1);
        chk("cf_busy", 32'(busy), 1);
        settle();
        chk("cf_idle", 32'(busy), 0);
        chk("cf_errk", 32'(err),  1);
        compare_writes("cf");

        // Abort: partial data frame, then a fresh load restarts at 0.
        start(1'b1);
        repeat (5) send_bit(1'b1);
        settle();
        compare_writes("abort");
        chk("ab_busy", 32'(busy), 0);
        chk("ab_err",  32'(err),  0);
        bytes.delete();
        bytes.push_back(8'h11);
        load(1'b1);

        // Wrap: 17 data bytes.
        bytes.delete();
        for (int k = 0; k < 17; k++) bytes.push_back(8'($urandom));
        load(1'b1);

        // Gating of proc_run around an instruction load.
        proc_en = 1'b1;
        repeat (SYNC + 3) tick();
        chk("gate_idle", 32'(proc_run), 1);
        begin
            logic [7:0] gb;
            gb = 8'($urandom);
            start(1'b0);
            exp_q.push_back({1'b0, 4'd0, gb});
            send_byte(gb);
        end
        chk("gate_ld", 32'(proc_run), 0);
        csi = 1'b1; csd = 1'b1; mosi = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("gate", 32'(proc_run), 32'(j >= SYNC + 1));
        end
        compare_writes("gate_wr");

        // Random loads.
        for (int r = 0; r < 6; r++) begin
            bit tgt;
            int n;
            tgt = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 20);
            proc_en = 1'($urandom_range(0, 1));
            bytes.delete();
            for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
            load(tgt);
        end

        // Reset in the middle of a data frame.
        start(1'b1);
        repeat (4) send_bit(1'b1);
        rst = 1'b1;
        csd = 1'b1;
        tick();
        tick();
        chk("mr_busy",  32'(busy),      0);
        chk("mr_wdata", 32'(wdata),     0);
        chk("mr_addr",  32'(dmem_addr), 0);
        rst = 1'b0;
        repeat (SYNC + 5) tick();
        compare_writes("mr");
        chk("mr_idle", 32'(busy), 0);

`ifdef LOADER_PARITY_EN
        // Bad-parity frame is dropped; the next good frame lands at address 0.
        begin
            logic [7:0] pb;
            pb = 8'h01;
            start(1'b1);
            for (int i = 7; i >= 0; i--) send_bit(pb[i]);
            send_bit(1'b0);
            exp_q.push_back({1'b1, 4'd0, 8'h5A});
            send_byte(8'h5A);
            settle();
            compare_writes("par");
            chk("perr", 32'(perr), 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
